// File: rtl/joy_pkg.sv
// Shared types and helpers for the joystick direction conditioner.
package joy_pkg;

  typedef enum logic [1:0] {
    JM_PASS   = 2'b00,
    JM_NEWEST = 2'b01,
    JM_FIRST  = 2'b10,
    JM_SOCD   = 2'b11
  } joy_mode_t;

  localparam int DIR_UP    = 3;
  localparam int DIR_DOWN  = 2;
  localparam int DIR_LEFT  = 1;
  localparam int DIR_RIGHT = 0;

  // Priority up > down > left > right when several bits are set.
  function automatic logic [3:0] hi_onehot(input logic [3:0] x);
    logic [3:0] r;
    r = 4'b0000;
    if (x[DIR_UP])         r = 4'b1000;
    else if (x[DIR_DOWN])  r = 4'b0100;
    else if (x[DIR_LEFT])  r = 4'b0010;
    else if (x[DIR_RIGHT]) r = 4'b0001;
    return r;
  endfunction

endpackage

// File: rtl/joy_debounce.sv
// Per-bit debounce of one player's 4-bit direction vector; a new level is
// accepted only after DB_CYCLES consecutive ce ticks of disagreement.
module joy_debounce
  import joy_pkg::*;
#(
  parameter int DB_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_i,
  input  logic [3:0] raw_i,
  output logic [3:0] deb_o
);

  generate
    if (DB_CYCLES == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = ^{clk, reset_n, ce_i};
      assign deb_o = raw_i;
    end else begin : g_count
      localparam int CW = $clog2(DB_CYCLES + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

      logic [CW-1:0] cnt_q [4];
      logic [CW-1:0] cnt_d [4];
      logic [3:0]    deb_q;
      logic [3:0]    deb_d;

      always_comb begin
        deb_d = deb_q;
        for (int b = 0; b < 4; b++) begin
          cnt_d[b] = '0;
          if (raw_i[b] != deb_q[b]) begin
            cnt_d[b] = cnt_q[b];
            // The tick that would make the count reach DB_CYCLES commits the bit.
            if (ce_i) begin
              if (cnt_q[b] == CNT_LAST) begin
                deb_d[b] = raw_i[b];
                cnt_d[b] = '0;
              end else begin
                cnt_d[b] = cnt_q[b] + 1'b1;
              end
            end
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          deb_q <= '0;
          for (int b = 0; b < 4; b++) cnt_q[b] <= '0;
        end else begin
          deb_q <= deb_d;
          for (int b = 0; b < 4; b++) cnt_q[b] <= cnt_d[b];
        end
      end

      assign deb_o = deb_q;
    end
  endgenerate

endmodule

// File: rtl/joy_dir_filter.sv
// Multi-player joystick conditioner: sample, debounce, then a per-player
// mode-selectable direction filter with registered output and change strobe.
module joy_dir_filter
  import joy_pkg::*;
#(
  parameter int PLAYERS   = 2,
  parameter int DB_CYCLES = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic [2*PLAYERS-1:0] mode,
  input  logic [4*PLAYERS-1:0] dir_in,
  output logic [4*PLAYERS-1:0] dir_out,
  output logic [PLAYERS-1:0]   changed
);

  generate
    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
      logic [3:0] raw_q, deb, prev_q;
      logic [3:0] sel_q, sel_d, sel_base;
      logic [3:0] out_q, out_d;
      logic [3:0] new_edge, held;
      logic       last_h_q, last_h_d, last_base;
      logic       chg_q, chg_d, mode_chg;
      joy_mode_t  mode_cur, mode_q;

      assign mode_cur = joy_mode_t'(mode[2*p +: 2]);

      joy_debounce #(.DB_CYCLES(DB_CYCLES)) u_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .ce_i    (ce),
        .raw_i   (raw_q),
        .deb_o   (deb)
      );

      // A mode switch drops selection history before this cycle's decision.
      assign mode_chg  = (mode_cur != mode_q);
      assign sel_base  = mode_chg ? 4'b0000 : sel_q;
      assign last_base = mode_chg ? 1'b0 : last_h_q;
      assign new_edge  = deb & ~prev_q;
      assign held      = deb & sel_base;

      always_comb begin
        sel_d    = sel_base;
        last_h_d = last_base;
        out_d    = deb;
        case (mode_cur)
          JM_PASS: begin
            sel_d = 4'b0000;
          end
          JM_NEWEST: begin
            if (new_edge != 4'b0000) sel_d = hi_onehot(new_edge);
            else if (held == 4'b0000) sel_d = hi_onehot(deb);
            out_d = deb & sel_d;
          end
          JM_FIRST: begin
            if (held == 4'b0000)
              sel_d = (new_edge != 4'b0000) ? hi_onehot(new_edge) : hi_onehot(deb);
            out_d = deb & sel_d;
          end
          JM_SOCD: begin
            if (new_edge[DIR_LEFT])       last_h_d = 1'b1;
            else if (new_edge[DIR_RIGHT]) last_h_d = 1'b0;
            if (deb[DIR_UP] && deb[DIR_DOWN]) begin
              out_d[DIR_UP]   = 1'b0;
              out_d[DIR_DOWN] = 1'b0;
            end
            if (deb[DIR_LEFT] && deb[DIR_RIGHT]) begin
              out_d[DIR_LEFT]  = last_h_d;
              out_d[DIR_RIGHT] = ~last_h_d;
            end
          end
        endcase
        chg_d = (out_d != out_q);
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          raw_q    <= 4'b0000;
          prev_q   <= 4'b0000;
          sel_q    <= 4'b0000;
          last_h_q <= 1'b0;
          mode_q   <= JM_PASS;
          out_q    <= 4'b0000;
          chg_q    <= 1'b0;
        end else begin
          raw_q    <= dir_in[4*p +: 4];
          prev_q   <= deb;
          sel_q    <= sel_d;
          last_h_q <= last_h_d;
          mode_q   <= mode_cur;
          out_q    <= out_d;
          chg_q    <= chg_d;
        end
      end

      assign dir_out[4*p +: 4] = out_q;
      assign changed[p]        = chg_q;
    end
  endgenerate

endmodule

// File: tb/tb_joy_dir_filter.sv
// Directed bench: a two-player unfiltered-debounce instance and a
// one-player instance with a 3-tick debounce.
module tb_joy_dir_filter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ce;
  logic [3:0] mode_a;
  logic [7:0] dir_a;
  logic [7:0] out_a;
  logic [1:0] chg_a;
  logic [1:0] mode_b;
  logic [3:0] dir_b;
  logic [3:0] out_b;
  logic [0:0] chg_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  joy_dir_filter #(.PLAYERS(2), .DB_CYCLES(0)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .mode    (mode_a),
    .dir_in  (dir_a),
    .dir_out (out_a),
    .changed (chg_a)
  );

  joy_dir_filter #(.PLAYERS(1), .DB_CYCLES(3)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .mode    (mode_b),
    .dir_in  (dir_b),
    .dir_out (out_b),
    .changed (chg_b)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ce      = 1'b1;
    mode_a  = 4'b0001;
    dir_a   = 8'h00;
    mode_b  = 2'b00;
    dir_b   = 4'h0;
    tick(2);
    vectors++;
    if (out_a !== 8'h00 || chg_a !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_a: out=%h chg=%b want out=00 chg=00", out_a, chg_a);
    end
    vectors++;
    if (out_b !== 4'h0 || chg_b !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_b: out=%h chg=%b want out=0 chg=0", out_b, chg_b);
    end
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_newest();
    logic [7:0] dv [4] = '{8'h01, 8'h09, 8'h01, 8'h00};
    logic [7:0] ev [4] = '{8'h01, 8'h08, 8'h01, 8'h00};
    mode_a = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      dir_a = dv[i];
      tick(2);
      vectors++;
      if (out_a !== ev[i] || chg_a !== 2'b01) begin
        miscompares++;
        $display("FAIL newest_%0d: out=%h chg=%b want out=%h chg=01", i, out_a, chg_a, ev[i]);
      end
      tick(1);
      vectors++;
      if (out_a !== ev[i] || chg_a !== 2'b00) begin
        miscompares++;
        $display("FAIL newest_hold_%0d: out=%h chg=%b want out=%h chg=00", i, out_a, chg_a, ev[i]);
      end
    end
  endtask

  task automatic test_first();
    logic [7:0] dv [4] = '{8'h02, 8'h06, 8'h04, 8'h00};
    logic [7:0] ev [4] = '{8'h02, 8'h02, 8'h04, 8'h00};
    logic [1:0] cv [4] = '{2'b01, 2'b00, 2'b01, 2'b01};
    mode_a = 4'b0010;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      dir_a = dv[i];
      tick(2);
      vectors++;
      if (out_a !== ev[i] || chg_a !== cv[i]) begin
        miscompares++;
        $display("FAIL first_%0d: out=%h chg=%b want out=%h chg=%b", i, out_a, chg_a, ev[i], cv[i]);
      end
    end
  endtask

  task automatic test_socd();
    logic [7:0] dv [6] = '{8'h0C, 8'h0D, 8'h01, 8'h03, 8'h01, 8'h00};
    logic [7:0] ev [6] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h01, 8'h00};
    mode_a = 4'b0011;
    tick(1);
    for (int i = 0; i < 6; i++) begin
      dir_a = dv[i];
      tick(2);
      vectors++;
      if (out_a !== ev[i]) begin
        miscompares++;
        $display("FAIL socd_%0d: out=%h want %h", i, out_a, ev[i]);
      end
    end
  endtask

  task automatic test_two_players();
    mode_a = 4'b0100;
    dir_a  = 8'h5A;
    tick(2);
    vectors++;
    if (out_a !== 8'h4A || chg_a !== 2'b11) begin
      miscompares++;
      $display("FAIL two_players: out=%h chg=%b want out=4a chg=11", out_a, chg_a);
    end
    mode_a = 4'b0101;
    tick(1);
    vectors++;
    if (out_a !== 8'h48 || chg_a !== 2'b01) begin
      miscompares++;
      $display("FAIL two_players_modesw: out=%h chg=%b want out=48 chg=01", out_a, chg_a);
    end
  endtask

  task automatic test_reset_mid();
    mode_a = 4'b0001;
    dir_a  = 8'h00;
    tick(2);
    dir_a = 8'h09;
    tick(2);
    vectors++;
    if (out_a !== 8'h08) begin
      miscompares++;
      $display("FAIL reset_mid_pre: out=%h want 08", out_a);
    end
    reset_n = 1'b0;
    tick(1);
    vectors++;
    if (out_a !== 8'h00 || chg_a !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_mid_zero: out=%h chg=%b want out=00 chg=00", out_a, chg_a);
    end
    reset_n = 1'b1;
    tick(1);
    vectors++;
    if (out_a !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mid_lat: out=%h want 00", out_a);
    end
    tick(1);
    vectors++;
    if (out_a !== 8'h08 || chg_a !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_mid_up: out=%h chg=%b want out=08 chg=01", out_a, chg_a);
    end
  endtask

  task automatic test_debounce();
    mode_b = 2'b00;
    dir_b  = 4'h0;
    tick(4);
    // Two-sample glitch on up must never appear.
    for (int i = 0; i < 8; i++) begin
      dir_b = (i < 2) ? 4'h8 : 4'h0;
      tick(1);
      vectors++;
      if (out_b !== 4'h0 || chg_b !== 1'b0) begin
        miscompares++;
        $display("FAIL deb_glitch_%0d: out=%h chg=%b want out=0 chg=0", i, out_b, chg_b);
      end
    end
    // Held press: visible after exactly 2 + 3 edges.
    dir_b = 4'h8;
    tick(4);
    vectors++;
    if (out_b !== 4'h0) begin
      miscompares++;
      $display("FAIL deb_early: out=%h want 0", out_b);
    end
    tick(1);
    vectors++;
    if (out_b !== 4'h8 || chg_b !== 1'b1) begin
      miscompares++;
      $display("FAIL deb_hold: out=%h chg=%b want out=8 chg=1", out_b, chg_b);
    end
    tick(1);
    vectors++;
    if (out_b !== 4'h8 || chg_b !== 1'b0) begin
      miscompares++;
      $display("FAIL deb_steady: out=%h chg=%b want out=8 chg=0", out_b, chg_b);
    end
    dir_b = 4'h0;
    tick(5);
    vectors++;
    if (out_b !== 4'h0 || chg_b !== 1'b1) begin
      miscompares++;
      $display("FAIL deb_release: out=%h chg=%b want out=0 chg=1", out_b, chg_b);
    end
    // Reset part-way through a count discards it.
    tick(2);
    dir_b = 4'h8;
    tick(3);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(4);
    vectors++;
    if (out_b !== 4'h0) begin
      miscompares++;
      $display("FAIL deb_reset_discard: out=%h want 0", out_b);
    end
    tick(1);
    vectors++;
    if (out_b !== 4'h8) begin
      miscompares++;
      $display("FAIL deb_after_reset: out=%h want 8", out_b);
    end
  endtask

  initial begin
    test_reset();
    test_newest();
    test_first();
    test_socd();
    test_two_players();
    test_reset_mid();
    test_debounce();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/joy_dir_filter.md
# joy_dir_filter

Multi-player, mode-selectable joystick direction conditioner placed between the merged joystick/keyboard direction vectors and the game core's IN0/IN1 assembly. Each player's 4-bit direction vector is debounced, then run through its own per-player filter. The filter is one of: passthrough, 4-way newest-wins, 4-way first-wins, or 8-way with SOCD cleaning. Outputs are registered and carry a per-player change strobe.

## Interface
Direction vectors use the bit order `{up, down, left, right}`, so bit 3 is up and bit 0 is right. Player p occupies bits `[4p+3:4p]`.

Parameters:
- `PLAYERS`, default 2: number of independent channels, 1..4.
- `DB_CYCLES`, default 0: number of consecutive `ce` ticks an input must hold its new value before it is accepted. 0 bypasses debounce.

Ports:
- `clk` in, 1: system clock.
- `reset_n` in, 1: reset, **synchronous, active-low**.
- `ce` in, 1: debounce tick enable. Ignored when `DB_CYCLES` = 0.
- `mode` in, 2*PLAYERS: per-player mode.
  - 00: pass
  - 01: 4-way newest-wins
  - 10: 4-way first-wins
  - 11: 8-way SOCD
- `dir_in` in, 4*PLAYERS: raw directions, active-high, asynchronous to game logic.
- `dir_out` out, 4*PLAYERS: filtered directions.
- `changed` out, PLAYERS: 1-cycle pulse when that player's `dir_out` changes.

## Operation
- **Sample stage:** `dir_in` is registered once into `raw`.
- **Debounce stage:** produces `deb`.
  - `DB_CYCLES` = 0: `deb` = `raw`.
  - Otherwise, each bit has a counter of width `$clog2(DB_CYCLES+1)`.
    - If `raw` ≠ `deb` and `ce`: the counter increments.
    - When the counter reaches `DB_CYCLES`: `deb` takes `raw` and the counter clears.
    - If `raw` = `deb`: the counter clears.
- **Edge detect:** `prev` <= `deb`, and `new` = `deb & ~prev`.
- **Selection register:** each player has a 4-bit one-hot-or-zero `sel`.
  - `held` = `deb & sel`.
  - `hi(x)` = one-hot of the highest set bit of x, or 0 if x is zero.
- **Mode 01 (newest-wins):**
  - If `new` ≠ 0: `sel_nxt` = `hi(new)`. On simultaneous presses the higher index wins (up > down > left > right).
  - Else if `held` = 0: `sel_nxt` = `hi(deb)`.
  - Else `sel` holds.
- **Mode 10 (first-wins):**
  - If `held` ≠ 0: `sel` holds, and new presses are ignored.
  - Otherwise `sel_nxt` = `hi(new)` if `new` ≠ 0, else `hi(deb)`.
- **Modes 01 and 10 output:** `dir_out` <= `deb & sel_nxt`. It is always one-hot or zero.
- **Mode 00:** `dir_out` <= `deb`, and `sel` is cleared.
- **Mode 11 (SOCD):**
  - Up and down both set: both outputs are 0 (vertical neutral).
  - Left and right both set: output the one most recently pressed, tracked in a per-player `last_h` bit updated on `new[1]` / `new[0]`. If both are pressed in the same cycle, left wins.
  - Otherwise `dir_out` <= `deb`.
- **Mode change:** when a player's `mode` differs from its value on the previous cycle, `sel` <= 0 and `last_h` <= 0 for that player. The output that cycle is computed with the new mode and the cleared state.
- **Change strobe:** `changed[p]` <= (next `dir_out[p]` ≠ current `dir_out[p]`).

## Timing
- **Reset values:** while `reset_n` = 0 at a clock edge, the following all go to 0: `raw`, `deb`, `prev`, all counters, `sel`, `last_h`, the stored mode, `dir_out` and `changed`.
- **Reset mid-debounce:** the count is discarded. There is no partial state after release.
- **First edge after reset:** `prev` = 0, so any input already held produces `new` edges. Mode 01/10 selection therefore resolves normally.
- **Latency, `DB_CYCLES` = 0:** `dir_in` to `dir_out` takes 2 clocks (sample, then output). `changed` is asserted in the same cycle `dir_out` updates.
- **Latency, `DB_CYCLES` = N:** 2 clocks plus N `ce` ticks after the first sampled differing value.
- **Glitch rejection:** a glitch shorter than N ticks never reaches `dir_out`.
- **Player independence:** channels share only `clk`, `reset_n` and `ce`.

## Structure
- Shared package `joy_pkg` holds:
  - enum `joy_mode_t` (`JM_PASS`, `JM_NEWEST`, `JM_FIRST`, `JM_SOCD`);
  - localparams `DIR_UP`=3, `DIR_DOWN`=2, `DIR_LEFT`=1, `DIR_RIGHT`=0;
  - function `hi_onehot`.
- Sub-module `joy_debounce`: 4-bit vector debounce, parameter `DB_CYCLES`, instantiated once per player.
- The filter logic is a generate loop over `PLAYERS` in the top module.

## Test plan
- **Mode 01, `DB_CYCLES`=0:** hold right (0001), then add up (1001). `dir_out` goes 0001 → 1000, with a `changed` pulse each time. Release up → 0001.
- **Mode 10:** hold left (0010), add down (0110). `dir_out` stays 0010. Release left → 0100 on the next output edge.
- **Mode 11:** apply 1100 → `dir_out` = 0000. Press right, then left (both held) → 0010. Release left → 0001.
- **Debounce, `DB_CYCLES`=3, `ce` every cycle:** a 2-cycle pulse on up gives no output and no `changed`. A 3-cycle hold gives `dir_out` = 1000, 2+3 cycles after the first sample.
- **Reset mid-operation:** assert `reset_n`=0 with 1001 held in mode 01. All outputs read 0 the next cycle. After release, `dir_out` = 1000 (simultaneous edges, up wins).
- **Two players:** P0 in mode 00 with 1010, P1 in mode 01 with 0101. `dir_out` = {0100, 1010}. Switching P0 to mode 01 clears its `sel` and yields 1000.
